// File: rtl/pwm_pkg.sv
// Shared PWM types: carrier modes, scheduler states and the per-channel
// configuration record used by the carrier configuration scheduler.
package pwm_pkg;

    localparam int CARR_W = 16;

    typedef enum logic [1:0] {
        COUNT_UPDOWN = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2
    } _count_mode;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MASK_ZERO   = 2'd1,
        MASK_PERIOD = 2'd2,
        MASK_BOTH   = 2'd3
    } _mask_mode;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } _sched_state;

    typedef struct packed {
        logic [CARR_W-1:0] period;
        logic [CARR_W-1:0] init;
        _count_mode        count_mode;
        _mask_mode         mask_mode;
    } _carr_cfg;

    localparam _carr_cfg CFG_RESET = '{
        period:     '0,
        init:       '0,
        count_mode: COUNT_UPDOWN,
        mask_mode:  NO_MASK
    };

endpackage

// File: rtl/carrier_cfg_sched_if.sv
// Configuration write port of the carrier scheduler: one valid/ready
// transaction carries a full channel configuration.
interface carrier_cfg_sched_if #(
    parameter int N_CH = 4,
    parameter int W    = 16
) ();
    import pwm_pkg::*;

    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             valid;
    logic             ready;
    logic [CHW-1:0]   ch;
    logic [W-1:0]     period;
    logic [W-1:0]     init;
    _count_mode       count_mode;
    _mask_mode        mask_mode;
    logic             immediate;

    modport master (
        output valid, ch, period, init, count_mode, mask_mode, immediate,
        input  ready
    );

    modport slave (
        input  valid, ch, period, init, count_mode, mask_mode, immediate,
        output ready
    );

endinterface

// File: rtl/carrier_cfg_slot.sv
// One carrier channel: shadow and active configuration, pending/stopped
// flags, boundary commit and the delayed reload pulse of immediate writes.
module carrier_cfg_slot
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  _sched_state       state,
    input  logic              we,
    input  logic              wr_imm,
    input  _carr_cfg          wr_cfg,
    input  logic              mask_event,
    input  logic              clr_stopped,
    output logic [CARR_W-1:0] period_out,
    output logic [CARR_W-1:0] init_out,
    output _count_mode        count_mode_out,
    output _mask_mode         mask_mode_out,
    output logic              carr_reset,
    output logic              pending,
    output logic              stopped
);

    _carr_cfg shadow;
    _carr_cfg act;
    logic     imm_p0;
    logic     imm_p1;

    // Shadow/active update: idle writes land directly, run writes wait for the
    // channel boundary unless immediate, stopping commits then parks the channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= CFG_RESET;
            act     <= CFG_RESET;
            pending <= 1'b0;
            stopped <= 1'b0;
            imm_p0  <= 1'b0;
            imm_p1  <= 1'b0;
        end else begin
            imm_p0 <= 1'b0;
            imm_p1 <= imm_p0;
            if (clr_stopped) begin
                stopped <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (we) begin
                        act <= wr_cfg;
                    end
                end
                SYNC: begin
                    if (pending) begin
                        act     <= shadow;
                        pending <= 1'b0;
                    end
                end
                RUN: begin
                    // A write is only accepted with pending clear, so an event in
                    // the accept cycle has nothing to commit and the write waits.
                    if (we) begin
                        if (wr_imm) begin
                            act    <= wr_cfg;
                            imm_p0 <= 1'b1;
                        end else begin
                            shadow  <= wr_cfg;
                            pending <= 1'b1;
                        end
                    end else if (pending && mask_event) begin
                        act     <= shadow;
                        pending <= 1'b0;
                    end
                end
                STOPPING: begin
                    if (mask_event && !stopped) begin
                        if (pending) begin
                            act     <= shadow;
                            pending <= 1'b0;
                        end
                        stopped <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Carriers hold while idle or once parked; reload on sync or after an immediate write.
    always_comb begin
        period_out     = (state == IDLE || stopped) ? '0 : act.period;
        init_out       = act.init;
        count_mode_out = act.count_mode;
        mask_mode_out  = act.mask_mode;
        carr_reset     = (state == SYNC) | imm_p1;
    end

endmodule

// File: rtl/carrier_cfg_sched.sv
// Carrier configuration scheduler: global start/stop sequencing, write
// acceptance and per-channel dispatch into N_CH configuration slots.
module carrier_cfg_sched
    import pwm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = CARR_W,
    parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    carrier_cfg_sched_if.slave     cfg,
    input  logic                   start,
    input  logic                   stop,
    input  logic [N_CH-1:0]        mask_event_in,
    output logic [N_CH*W-1:0]      period_o,
    output logic [N_CH*W-1:0]      init_o,
    output _count_mode [N_CH-1:0]  count_mode_o,
    output _mask_mode  [N_CH-1:0]  mask_mode_o,
    output logic [N_CH-1:0]        carr_reset_o,
    output logic [N_CH-1:0]        pending_o,
    output logic                   run_o
);

    localparam int N_SLOT = 1 << CHW;

    _sched_state       state;
    logic [N_CH-1:0]   stopped;
    logic [N_SLOT-1:0] pend_ext;
    logic              accept;
    logic              clr_stopped;
    _carr_cfg          wr_cfg;

    // Global sequencer: start wins in IDLE, stop wins in RUN, STOPPING drains per channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:     if (start) state <= SYNC;
                SYNC:     state <= RUN;
                RUN:      if (stop) state <= STOPPING;
                STOPPING: if (&stopped) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Ready decode and write demux; out-of-range channels accept and match no slot.
    always_comb begin
        pend_ext             = '0;
        pend_ext[N_CH-1:0]   = pending_o;
        cfg.ready            = (state == IDLE) || (state == RUN && !pend_ext[cfg.ch]);
        accept               = cfg.valid && cfg.ready;
        clr_stopped          = (state == STOPPING) && (&stopped);
        run_o                = (state != IDLE);
        wr_cfg.period        = cfg.period;
        wr_cfg.init          = cfg.init;
        wr_cfg.count_mode    = cfg.count_mode;
        wr_cfg.mask_mode     = cfg.mask_mode;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        logic [CARR_W-1:0] slot_period;
        logic [CARR_W-1:0] slot_init;

        carrier_cfg_slot u_slot (
            .clk            (clk),
            .reset          (reset),
            .state          (state),
            .we             (accept && (cfg.ch == CHW'(i))),
            .wr_imm         (cfg.immediate),
            .wr_cfg         (wr_cfg),
            .mask_event     (mask_event_in[i]),
            .clr_stopped    (clr_stopped),
            .period_out     (slot_period),
            .init_out       (slot_init),
            .count_mode_out (count_mode_o[i]),
            .mask_mode_out  (mask_mode_o[i]),
            .carr_reset     (carr_reset_o[i]),
            .pending        (pending_o[i]),
            .stopped        (stopped[i])
        );

        assign period_o[i*W +: W] = slot_period;
        assign init_o[i*W +: W]   = slot_init;
    end

endmodule

// File: tb/tb_carrier_cfg_sched.sv
// Directed bench for carrier_cfg_sched: stimulus queues expected values
// tagged with the cycle they apply to, a monitor checks them.
module tb_carrier_cfg_sched;
    import pwm_pkg::*;

    localparam int N_CH = 4;
    localparam int W    = 16;

    typedef enum int {F_PERIOD, F_INIT, F_CMODE, F_MMODE, F_CRST, F_PEND, F_RUN, F_READY} fld_e;

    typedef struct {
        string       name;
        int          cyc;
        fld_e        f;
        int          ch;
        logic [31:0] val;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  stop;
    logic [N_CH-1:0]       mask_event_in;
    logic [N_CH*W-1:0]     period_o;
    logic [N_CH*W-1:0]     init_o;
    _count_mode [N_CH-1:0] count_mode_o;
    _mask_mode  [N_CH-1:0] mask_mode_o;
    logic [N_CH-1:0]       carr_reset_o;
    logic [N_CH-1:0]       pending_o;
    logic                  run_o;

    carrier_cfg_sched_if #(.N_CH(N_CH), .W(W)) cfg_if ();

    carrier_cfg_sched #(.N_CH(N_CH), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg           (cfg_if),
        .start         (start),
        .stop          (stop),
        .mask_event_in (mask_event_in),
        .period_o      (period_o),
        .init_o        (init_o),
        .count_mode_o  (count_mode_o),
        .mask_mode_o   (mask_mode_o),
        .carr_reset_o  (carr_reset_o),
        .pending_o     (pending_o),
        .run_o         (run_o)
    );

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    event now_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(fld_e f, int ch);
        case (f)
            F_PERIOD: return 32'(period_o[ch*W +: W]);
            F_INIT:   return 32'(init_o[ch*W +: W]);
            F_CMODE:  return 32'(count_mode_o[ch]);
            F_MMODE:  return 32'(mask_mode_o[ch]);
            F_CRST:   return 32'(carr_reset_o);
            F_PEND:   return 32'(pending_o);
            F_RUN:    return 32'(run_o);
            default:  return 32'(cfg_if.ready);
        endcase
    endfunction

    task automatic scan(input int c);
        exp_t        e;
        logic [31:0] a;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == c) begin
                e = sb[i];
                a = actual(e.f, e.ch);
                n_vec++;
                if (a !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", e.name, a, e.val, $time);
                end
                sb.delete(i);
            end
        end
    endtask

    // Monitor: clocked checks at the falling edge, plus on-demand checks.
    initial forever begin
        @(negedge clk);
        scan(cyc);
    end

    initial forever begin
        @(now_ev);
        scan(-1);
    end

    task automatic expect_at(input string name, input int delta, input fld_e f, input int ch, input int val);
        exp_t e;
        e.name = name;
        e.cyc  = (delta < 0) ? -1 : cyc + delta;
        e.f    = f;
        e.ch   = ch;
        e.val  = 32'(val);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int per, input int ini,
                             input _count_mode cm, input _mask_mode mm, input logic imm);
        cfg_if.valid      = 1'b1;
        cfg_if.ch         = 2'(ch);
        cfg_if.period     = 16'(per);
        cfg_if.init       = 16'(ini);
        cfg_if.count_mode = cm;
        cfg_if.mask_mode  = mm;
        cfg_if.immediate  = imm;
        tick();
        cfg_if.valid      = 1'b0;
        cfg_if.immediate  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mask_event_in = '0;
        cfg_if.valid = 1'b0;
        cfg_if.ch = '0;
        cfg_if.period = '0;
        cfg_if.init = '0;
        cfg_if.count_mode = COUNT_UPDOWN;
        cfg_if.mask_mode = NO_MASK;
        cfg_if.immediate = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        expect_at("rst_run", 0, F_RUN, 0, 0);
        expect_at("rst_pend", 0, F_PEND, 0, 0);
        expect_at("rst_crst", 0, F_CRST, 0, 0);
        expect_at("rst_period2", 0, F_PERIOD, 2, 0);
        expect_at("rst_cmode0", 0, F_CMODE, 0, COUNT_UPDOWN);
        expect_at("rst_ready", 0, F_READY, 0, 1);
        tick();

        // Idle writes commit directly; period stays held at 0.
        cfg_write(1, 100, 0, COUNT_UP, MASK_BOTH, 1'b0);
        expect_at("idle_init1", 0, F_INIT, 1, 0);
        expect_at("idle_cmode1", 0, F_CMODE, 1, COUNT_UP);
        expect_at("idle_mmode1", 0, F_MMODE, 1, MASK_BOTH);
        expect_at("idle_period1", 0, F_PERIOD, 1, 0);
        expect_at("idle_pend", 0, F_PEND, 0, 0);
        cfg_write(2, 40, 33, COUNT_DOWN, MASK_ZERO, 1'b0);
        expect_at("idle_init2", 0, F_INIT, 2, 33);
        cfg_write(0, 10, 0, COUNT_UPDOWN, NO_MASK, 1'b0);
        expect_at("idle_period0", 0, F_PERIOD, 0, 0);
        tick();

        // Start together with stop in IDLE: start wins.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        expect_at("sync_crst", 0, F_CRST, 0, 4'b1111);
        expect_at("sync_run", 0, F_RUN, 0, 1);
        expect_at("sync_period0", 0, F_PERIOD, 0, 10);
        expect_at("sync_ready", 0, F_READY, 0, 0);
        expect_at("run_crst", 1, F_CRST, 0, 0);
        expect_at("run_period0", 1, F_PERIOD, 0, 10);
        expect_at("run_period1", 1, F_PERIOD, 1, 100);
        expect_at("run_ready", 1, F_READY, 0, 1);
        tick();
        tick();

        // Boundary commit on ch0.
        cfg_write(0, 20, 3, COUNT_UP, NO_MASK, 1'b0);
        expect_at("bnd_pend", 0, F_PEND, 0, 4'b0001);
        expect_at("bnd_ready0", 0, F_READY, 0, 0);
        expect_at("bnd_hold0", 0, F_PERIOD, 0, 10);
        repeat (50) tick();
        expect_at("bnd_hold50", 0, F_PERIOD, 0, 10);
        expect_at("bnd_pend50", 0, F_PEND, 0, 4'b0001);
        mask_event_in = 4'b0001;
        tick();
        mask_event_in = '0;
        expect_at("bnd_period0", 0, F_PERIOD, 0, 20);
        expect_at("bnd_init0", 0, F_INIT, 0, 3);
        expect_at("bnd_clear", 0, F_PEND, 0, 0);
        tick();

        // Accept and event on ch2 in the same cycle: commit waits for the next event.
        mask_event_in = 4'b0100;
        cfg_write(2, 77, 33, COUNT_DOWN, MASK_ZERO, 1'b0);
        mask_event_in = '0;
        expect_at("col_pend", 0, F_PEND, 0, 4'b0100);
        expect_at("col_hold", 0, F_PERIOD, 2, 40);
        repeat (3) tick();
        expect_at("col_hold3", 0, F_PERIOD, 2, 40);
        mask_event_in = 4'b0100;
        tick();
        mask_event_in = '0;
        expect_at("col_commit", 0, F_PERIOD, 2, 77);
        expect_at("col_clear", 0, F_PEND, 0, 0);
        tick();

        // Immediate write on ch3 and its delayed reload pulse.
        cfg_write(3, 5, 0, COUNT_UP, MASK_PERIOD, 1'b1);
        expect_at("imm_period3", 0, F_PERIOD, 3, 5);
        expect_at("imm_crst0", 0, F_CRST, 0, 0);
        expect_at("imm_pend", 0, F_PEND, 0, 0);
        expect_at("imm_crst1", 1, F_CRST, 0, 4'b1000);
        expect_at("imm_crst2", 2, F_CRST, 0, 0);
        repeat (3) tick();

        // Pending ch1 write, then stop together with start: stop wins.
        cfg_write(1, 200, 9, COUNT_UP, MASK_BOTH, 1'b0);
        expect_at("stp_pend1", 0, F_PEND, 0, 4'b0010);
        cfg_if.ch = 2'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        expect_at("stp_run", 0, F_RUN, 0, 1);
        expect_at("stp_ready", 0, F_READY, 0, 0);
        expect_at("stp_crst", 0, F_CRST, 0, 0);
        tick();
        mask_event_in = 4'b0111;
        tick();
        mask_event_in = '0;
        expect_at("stp_period0", 0, F_PERIOD, 0, 0);
        expect_at("stp_period1", 0, F_PERIOD, 1, 0);
        expect_at("stp_period2", 0, F_PERIOD, 2, 0);
        expect_at("stp_period3", 0, F_PERIOD, 3, 5);
        expect_at("stp_init1", 0, F_INIT, 1, 9);
        expect_at("stp_pend", 0, F_PEND, 0, 0);
        expect_at("stp_run2", 0, F_RUN, 0, 1);
        tick();
        mask_event_in = 4'b1000;
        tick();
        mask_event_in = '0;
        expect_at("stp_period3z", 0, F_PERIOD, 3, 0);
        expect_at("stp_run3", 0, F_RUN, 0, 1);
        expect_at("idle_run", 1, F_RUN, 0, 0);
        expect_at("idle_ready", 1, F_READY, 0, 1);
        expect_at("idle_period1b", 1, F_PERIOD, 1, 0);
        repeat (2) tick();

        // Second run, then asynchronous reset in STOPPING.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_at("sync2_crst", 0, F_CRST, 0, 4'b1111);
        expect_at("run2_period1", 1, F_PERIOD, 1, 200);
        repeat (2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_at("stp2_period0", 0, F_PERIOD, 0, 20);
        expect_at("stp2_ready", 0, F_READY, 0, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        expect_at("ares_run", -1, F_RUN, 0, 0);
        expect_at("ares_period0", -1, F_PERIOD, 0, 0);
        expect_at("ares_init0", -1, F_INIT, 0, 0);
        expect_at("ares_init2", -1, F_INIT, 2, 0);
        expect_at("ares_cmode1", -1, F_CMODE, 1, COUNT_UPDOWN);
        expect_at("ares_mmode1", -1, F_MMODE, 1, NO_MASK);
        expect_at("ares_pend", -1, F_PEND, 0, 0);
        expect_at("ares_crst", -1, F_CRST, 0, 0);
        ->now_ev;
        #1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();

        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: never checked, expected 'h%0h", sb[i].name, sb[i].val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
